ex_mem_stage: RTL and testbench

- EX/MEM pipeline boundary directly downstream of the 16-bit shifter and ALU.
- Each cycle it selects the shifter or ALU result by opcode and computes N/Z/V.
- It updates the architectural flag register and captures the result plus control into the MEM stage.
- It supports stall, flush and a sticky halt latch.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/flag_reg.sv | 30 +++
 rtl/ex_mem_stage.sv | 107 ++++++++++
 tb/tb_ex_mem_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode, flag-mask and width definitions for the 16-bit core.
// Imported by the EX/MEM boundary and the flag register.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_BR  = 4'b1010;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Mask bit order is {N, Z, V}
  localparam logic [2:0] FLAG_WR_NZV  = 3'b111;
  localparam logic [2:0] FLAG_WR_Z    = 3'b010;
  localparam logic [2:0] FLAG_WR_NONE = 3'b000;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRA) ||
           (op == OP_ROR);
  endfunction

endpackage

// File: rtl/flag_reg.sv
// Architectural N/Z/V register with per-flag write mask.
// Mask order is {N, Z, V}; unmasked flags hold.
module flag_reg
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] wr_mask,
  input  logic       n_nxt,
  input  logic       z_nxt,
  input  logic       v_nxt,
  output logic       n,
  output logic       z,
  output logic       v
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 1'b0;
      z <= 1'b0;
      v <= 1'b0;
    end else if (en) begin
      if (wr_mask[2]) n <= n_nxt;
      if (wr_mask[1]) z <= z_nxt;
      if (wr_mask[0]) v <= v_nxt;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: result select, flag update, MEM capture,
// stall/flush handling and the sticky halt latch.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] shift_result,
  input  logic              alu_ovfl,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_we,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_reg_we,
  output logic              mem_mem_rd,
  output logic              mem_mem_wr,
  output logic [DATA_W-1:0] mem_store_data,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v,
  output logic              halted
);

  logic [DATA_W-1:0] result;
  logic [2:0]        wr_mask;
  logic              is_arith;
  logic              is_zop;
  logic              take;
  logic              kill;

  assign result = is_shift_op(ex_opcode) ?
                  shift_result : alu_result;

  assign is_arith = (ex_opcode == OP_ADD) ||
                    (ex_opcode == OP_SUB);
  assign is_zop   = (ex_opcode == OP_XOR) ||
                    is_shift_op(ex_opcode);

  always_comb begin
    wr_mask = FLAG_WR_NONE;
    unique case (1'b1)
      is_arith: wr_mask = FLAG_WR_NZV;
      is_zop:   wr_mask = FLAG_WR_Z;
      default:  wr_mask = FLAG_WR_NONE;
    endcase
  end

  // Once halted, every capture degrades to a bubble
  assign kill = flush | halted;
  assign take = ex_valid & ~stall & ~kill;

  flag_reg u_flags (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (take),
    .wr_mask (wr_mask),
    .n_nxt   (result[DATA_W-1]),
    .z_nxt   (result == '0),
    .v_nxt   (alu_ovfl),
    .n       (flag_n),
    .z       (flag_z),
    .v       (flag_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_rd         <= '0;
      mem_reg_we     <= 1'b0;
      mem_mem_rd     <= 1'b0;
      mem_mem_wr     <= 1'b0;
      mem_store_data <= '0;
      halted         <= 1'b0;
    end else if (stall) begin
      halted <= halted;
    end else if (kill) begin
      mem_valid  <= 1'b0;
      mem_reg_we <= 1'b0;
      mem_mem_rd <= 1'b0;
      mem_mem_wr <= 1'b0;
    end else begin
      mem_valid      <= ex_valid;
      mem_result     <= result;
      mem_rd         <= ex_rd;
      mem_reg_we     <= ex_reg_we & ex_valid;
      mem_mem_rd     <= ex_mem_rd & ex_valid;
      mem_mem_wr     <= ex_mem_wr & ex_valid;
      mem_store_data <= ex_store_data;
      if (ex_valid && ex_opcode == OP_HLT)
        halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized + directed bench for ex_mem_stage against a
// behavioural model of the EX/MEM capture and flag rules.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] alu_result;
  logic [15:0] shift_result;
  logic        alu_ovfl;
  logic [3:0]  ex_rd;
  logic        ex_reg_we;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [15:0] ex_store_data;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic [15:0] mem_result;
  logic [3:0]  mem_rd;
  logic        mem_reg_we;
  logic        mem_mem_rd;
  logic        mem_mem_wr;
  logic [15:0] mem_store_data;
  logic        flag_n;
  logic        flag_z;
  logic        flag_v;
  logic        halted;

  int checks = 0;
  int errors = 0;

  // Model state
  logic        m_valid, m_we, m_mrd, m_mwr, m_halt;
  logic [15:0] m_result, m_sd;
  logic [3:0]  m_rd;
  logic        f_n, f_z, f_v;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .alu_result     (alu_result),
    .shift_result   (shift_result),
    .alu_ovfl       (alu_ovfl),
    .ex_rd          (ex_rd),
    .ex_reg_we      (ex_reg_we),
    .ex_mem_rd      (ex_mem_rd),
    .ex_mem_wr      (ex_mem_wr),
    .ex_store_data  (ex_store_data),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_result     (mem_result),
    .mem_rd         (mem_rd),
    .mem_reg_we     (mem_reg_we),
    .mem_mem_rd     (mem_mem_rd),
    .mem_mem_wr     (mem_mem_wr),
    .mem_store_data (mem_store_data),
    .flag_n         (flag_n),
    .flag_z         (flag_z),
    .flag_v         (flag_v),
    .halted         (halted)
  );

  task automatic chk(input string nm,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_mrd = 0; m_mwr = 0;
    m_halt = 0; m_result = 0; m_sd = 0; m_rd = 0;
    f_n = 0; f_z = 0; f_v = 0;
  endtask

  // Next-state prediction from the current EX inputs
  task automatic model_step();
    logic [15:0] r;
    int op;
    op = ex_opcode;
    r = (op >= 4 && op <= 6) ? shift_result : alu_result;
    if (stall) return;
    if (flush || m_halt) begin
      m_valid = 0; m_we = 0; m_mrd = 0; m_mwr = 0;
      return;
    end
    m_valid = ex_valid;
    m_result = r;
    m_rd = ex_rd;
    m_sd = ex_store_data;
    m_we = ex_valid && ex_reg_we;
    m_mrd = ex_valid && ex_mem_rd;
    m_mwr = ex_valid && ex_mem_wr;
    if (!ex_valid) return;
    if (op == 0 || op == 1) begin
      f_n = r[15]; f_z = (r == 0); f_v = alu_ovfl;
    end else if (op == 2 || (op >= 4 && op <= 6)) begin
      f_z = (r == 0);
    end
    if (op == 15) m_halt = 1;
  endtask

  task automatic check_model();
    chk("valid", 16'(mem_valid), 16'(m_valid));
    chk("result", mem_result, m_result);
    chk("rd", 16'(mem_rd), 16'(m_rd));
    chk("reg_we", 16'(mem_reg_we), 16'(m_we));
    chk("mem_rd", 16'(mem_mem_rd), 16'(m_mrd));
    chk("mem_wr", 16'(mem_mem_wr), 16'(m_mwr));
    chk("store", mem_store_data, m_sd);
    chk("flags", 16'({flag_n, flag_z, flag_v}),
        16'({f_n, f_z, f_v}));
    chk("halted", 16'(halted), 16'(m_halt));
  endtask

  task automatic idle();
    ex_valid = 0; ex_opcode = 0; alu_result = 0;
    shift_result = 0; alu_ovfl = 0; ex_rd = 0;
    ex_reg_we = 0; ex_mem_rd = 0; ex_mem_wr = 0;
    ex_store_data = 0; stall = 0; flush = 0;
  endtask

  task automatic ex(input logic [3:0] op,
                    input logic [15:0] alu,
                    input logic [15:0] sh,
                    input logic ov);
    idle();
    ex_valid = 1; ex_opcode = op; alu_result = alu;
    shift_result = sh; alu_ovfl = ov;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    #1;
    check_model();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    #2;
    check_model();
    chk("rst_valid", 16'(mem_valid), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // SUB then XOR to reach NZV=110, then SLL zero
    ex(4'b0001, 16'h8000, 16'h0, 0); step();
    chk("sub_nzv", 16'({flag_n, flag_z, flag_v}), 16'h4);
    ex(4'b0010, 16'h0000, 16'h0, 0); step();
    chk("xor_nzv", 16'({flag_n, flag_z, flag_v}), 16'h6);
    ex(4'b0100, 16'h1234, 16'h0000, 1); step();
    chk("sll_res", mem_result, 16'h0000);
    chk("sll_nzv", 16'({flag_n, flag_z, flag_v}), 16'h6);
    ex(4'b0110, 16'h0000, 16'h8001, 1); step();
    chk("ror_res", mem_result, 16'h8001);
    chk("ror_nzv", 16'({flag_n, flag_z, flag_v}), 16'h4);
    ex(4'b0000, 16'h8000, 16'h0, 1); step();
    chk("add_nzv", 16'({flag_n, flag_z, flag_v}), 16'h5);

    // Load, then stall+flush, then flush
    ex(4'b1000, 16'h0040, 16'h0, 0);
    ex_rd = 3; ex_mem_rd = 1; ex_reg_we = 1; step();
    chk("lw_mrd", 16'(mem_mem_rd), 16'h1);
    ex(4'b0001, 16'h0000, 16'h0, 0);
    stall = 1; flush = 1; step();
    chk("sf_mrd", 16'(mem_mem_rd), 16'h1);
    chk("sf_rd", 16'(mem_rd), 16'h3);
    stall = 0; step();
    chk("fl_valid", 16'(mem_valid), 16'h0);
    chk("fl_mrd", 16'(mem_mem_rd), 16'h0);
    chk("fl_res", mem_result, 16'h0040);
    chk("fl_nzv", 16'({flag_n, flag_z, flag_v}), 16'h5);

    // Bubble must not assert controls or flags
    ex(4'b0001, 16'h0000, 16'h0, 0);
    ex_valid = 0; ex_reg_we = 1; ex_mem_wr = 1; step();
    chk("bub_we", 16'(mem_reg_we), 16'h0);
    chk("bub_wr", 16'(mem_mem_wr), 16'h0);
    chk("bub_nzv", 16'({flag_n, flag_z, flag_v}), 16'h5);

    // Reach NZV=111 with mem_valid=1, then async reset
    ex(4'b0010, 16'h0000, 16'h0, 0); step();
    chk("pre_nzv", 16'({flag_n, flag_z, flag_v}), 16'h7);
    do_reset();
    chk("rst_nzv", 16'({flag_n, flag_z, flag_v}), 16'h0);
    ex(4'b0000, 16'h0005, 16'h0, 0); step();
    chk("post_res", mem_result, 16'h0005);
    chk("post_valid", 16'(mem_valid), 16'h1);

    // Random phase with periodic resets
    for (int i = 0; i < 600; i++) begin
      if (i % 75 == 74) begin
        idle();
        do_reset();
      end
      idle();
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_opcode = 4'($urandom_range(0, 15));
      if (ex_opcode == 4'hF && $urandom_range(0, 7) != 0)
        ex_opcode = 4'h0;
      alu_result = ($urandom_range(0, 3) == 0) ? 16'h0 :
                   16'($urandom);
      shift_result = ($urandom_range(0, 3) == 0) ? 16'h0 :
                     16'($urandom);
      alu_ovfl = 1'($urandom);
      ex_rd = 4'($urandom);
      ex_reg_we = 1'($urandom);
      ex_mem_rd = 1'($urandom);
      ex_mem_wr = 1'($urandom);
      ex_store_data = 16'($urandom);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 5) == 0);
      step();
    end

    // Halt: HLT with flush is discarded, then real HLT
    idle();
    do_reset();
    ex(4'b1111, 16'h0, 16'h0, 0); flush = 1; step();
    chk("hlt_fl", 16'(halted), 16'h0);
    ex(4'b0001, 16'h0001, 16'h0, 0); step();
    ex(4'b1111, 16'h0, 16'h0, 0); step();
    chk("hlt_set", 16'(halted), 16'h1);
    ex(4'b0000, 16'h0000, 16'h0, 0); step();
    chk("hlt_valid", 16'(mem_valid), 16'h0);
    chk("hlt_z", 16'(flag_z), 16'h0);
    ex(4'b0000, 16'h0000, 16'h0, 0); step();
    chk("hlt_stick", 16'(halted), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
